// File: rtl/bavul_pkg.sv
// Shared types, default constants and helpers for the baggage check-in unit.
package bavul_pkg;

  // Controller states of the check-in unit.
  typedef enum logic [1:0] {
    BOS    = 2'd0,
    HESAP  = 2'd1,
    SONUC  = 2'd2,
    KAPALI = 2'd3
  } durum_t;

  // Default parameter values for one flight.
  localparam int VARS_AGIRLIK_W   = 6;
  localparam int VARS_UCRET_W     = 8;
  localparam int VARS_YUK_W       = 12;
  localparam int VARS_SABIT_UCRET = 45;
  localparam int VARS_ESIK        = 60;
  localparam int VARS_BOLEN       = 20;
  localparam int VARS_KAPASITE    = 3000;
  localparam int VARS_MAX_YOLCU   = 50;

  // Clamp a value to the largest number representable in 'genislik' bits.
  function automatic logic [31:0] doyur(input logic [31:0] deger, input int genislik);
    logic [31:0] tavan;
    if (genislik >= 32) begin
      tavan = 32'hFFFF_FFFF;
    end else begin
      tavan = (32'd1 << genislik) - 32'd1;
    end
    return (deger > tavan) ? tavan : deger;
  endfunction

endpackage

// File: rtl/bavul_kabul_seri_bolucu.sv
// Fixed-latency restoring divider, one quotient bit per clock.
// The first bit is produced on the start edge, so the result is ready
// BOLUNEN_W edges after start and 'bitti_o' pulses in that cycle.
module seri_bolucu #(
  parameter int BOLUNEN_W = 12,
  parameter int BOLEN_W   = 5
) (
  input  logic                 saat,
  input  logic                 reset,
  input  logic                 basla_i,
  input  logic [BOLUNEN_W-1:0] bolunen_i,
  input  logic [BOLEN_W-1:0]   bolen_i,
  output logic [BOLUNEN_W-1:0] bolum_o,
  output logic                 bitti_o
);

  localparam int SAYAC_W = $clog2(BOLUNEN_W + 1);

  logic [BOLUNEN_W-1:0] bolum_q, bolum_d;
  logic [BOLEN_W-1:0]   kalan_q, kalan_d;
  logic [SAYAC_W-1:0]   sayac_q, sayac_d;
  logic                 mesgul_q, mesgul_d;
  logic                 bitti_q, bitti_d;

  logic [BOLUNEN_W-1:0] kaynakBolum;
  logic [BOLEN_W-1:0]   kaynakKalan;
  logic [BOLEN_W:0]     kaydir;
  logic                 sigar;
  logic [BOLEN_W-1:0]   adimKalan;
  logic [BOLUNEN_W-1:0] adimBolum;

  // One restoring step: a start restarts from a zero remainder and the new dividend.
  always_comb begin
    kaynakKalan = basla_i ? '0 : kalan_q;
    kaynakBolum = basla_i ? bolunen_i : bolum_q;
    kaydir      = {kaynakKalan, kaynakBolum[BOLUNEN_W-1]};
    sigar       = (kaydir >= {1'b0, bolen_i});
    adimKalan   = sigar ? BOLEN_W'(kaydir - {1'b0, bolen_i}) : kaydir[BOLEN_W-1:0];
    adimBolum   = {kaynakBolum[BOLUNEN_W-2:0], sigar};
  end

  // Sequencing: load on start, step while busy, pulse done after the last bit.
  always_comb begin
    bolum_d  = bolum_q;
    kalan_d  = kalan_q;
    sayac_d  = sayac_q;
    mesgul_d = mesgul_q;
    bitti_d  = 1'b0;
    if (basla_i) begin
      bolum_d  = adimBolum;
      kalan_d  = adimKalan;
      sayac_d  = SAYAC_W'(BOLUNEN_W - 1);
      mesgul_d = 1'b1;
    end else if (mesgul_q) begin
      bolum_d = adimBolum;
      kalan_d = adimKalan;
      sayac_d = sayac_q - SAYAC_W'(1);
      if (sayac_q == SAYAC_W'(1)) begin
        mesgul_d = 1'b0;
        bitti_d  = 1'b1;
      end
    end
  end

  // Divider state registers; an asynchronous reset abandons any division.
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      bolum_q  <= '0;
      kalan_q  <= '0;
      sayac_q  <= '0;
      mesgul_q <= 1'b0;
      bitti_q  <= 1'b0;
    end else begin
      bolum_q  <= bolum_d;
      kalan_q  <= kalan_d;
      sayac_q  <= sayac_d;
      mesgul_q <= mesgul_d;
      bitti_q  <= bitti_d;
    end
  end

  assign bolum_o = bolum_q;
  assign bitti_o = bitti_q;

endmodule

// File: rtl/bavul_kabul.sv
// Baggage check-in unit for one flight: accepts bags, tracks hold load and
// passenger count, computes the bag fee and closes the flight on demand or
// when the passenger limit is reached.
module bavul_kabul
  import bavul_pkg::*;
#(
  parameter int AGIRLIK_W   = VARS_AGIRLIK_W,
  parameter int UCRET_W     = VARS_UCRET_W,
  parameter int YUK_W       = VARS_YUK_W,
  parameter int SABIT_UCRET = VARS_SABIT_UCRET,
  parameter int ESIK        = VARS_ESIK,
  parameter int BOLEN       = VARS_BOLEN,
  parameter int KAPASITE    = VARS_KAPASITE,
  parameter int MAX_YOLCU   = VARS_MAX_YOLCU
) (
  input  logic                               saat,
  input  logic                               reset,
  input  logic                               basla,
  input  logic [AGIRLIK_W-1:0]               agirlik,
  input  logic                               kapat,
  output logic                               hazir,
  output logic [UCRET_W-1:0]                 ucret,
  output logic                               bitti,
  output logic                               red,
  output logic                               kapandi,
  output logic [YUK_W-1:0]                   toplam_yuk,
  output logic [$clog2(MAX_YOLCU+1)-1:0]     yolcu_sayisi
);

  localparam int YOLCU_W   = $clog2(MAX_YOLCU + 1);
  localparam int BOLUNEN_W = 2 * AGIRLIK_W;
  localparam int BOLEN_W   = $clog2(BOLEN + 1);
  localparam logic [BOLEN_W-1:0] BOLEN_SABIT = BOLEN_W'(BOLEN);

  durum_t               durum_q, durum_d;
  logic [YUK_W-1:0]     yuk_q, yuk_d;
  logic [YOLCU_W-1:0]   yolcu_q, yolcu_d;
  logic [UCRET_W-1:0]   ucret_q, ucret_d;
  logic                 red_q, red_d;
  logic                 bitti_q, bitti_d;
  logic                 kapat_q, kapat_d;
  logic                 duz_q, duz_d;
  logic                 ret_q, ret_d;

  logic [YUK_W:0]       yeni;
  logic                 kapanis;
  logic                 bolBasla;
  logic                 bolBitti;
  logic [BOLUNEN_W-1:0] bolunen;
  logic [BOLUNEN_W-1:0] bolum;

  assign yeni    = {1'b0, yuk_q} + (YUK_W + 1)'(agirlik);
  assign bolunen = BOLUNEN_W'(agirlik) * BOLUNEN_W'(agirlik);

  seri_bolucu #(
    .BOLUNEN_W (BOLUNEN_W),
    .BOLEN_W   (BOLEN_W)
  ) u_bolucu (
    .saat      (saat),
    .reset     (reset),
    .basla_i   (bolBasla),
    .bolunen_i (bolunen),
    .bolen_i   (BOLEN_SABIT),
    .bolum_o   (bolum),
    .bitti_o   (bolBitti)
  );

  // Controller: accept/reject in BOS, wait for the divider, publish the
  // result on leaving SONUC, and latch close requests arriving mid-bag.
  always_comb begin
    durum_d  = durum_q;
    yuk_d    = yuk_q;
    yolcu_d  = yolcu_q;
    ucret_d  = ucret_q;
    red_d    = red_q;
    bitti_d  = 1'b0;
    kapat_d  = kapat_q;
    duz_d    = duz_q;
    ret_d    = ret_q;
    bolBasla = 1'b0;
    kapanis  = kapat_q || kapat || (yolcu_q == YOLCU_W'(MAX_YOLCU));
    case (durum_q)
      BOS: begin
        if (kapat) begin
          durum_d = KAPALI;
        end else if (basla) begin
          if (yeni > (YUK_W + 1)'(KAPASITE)) begin
            ret_d   = 1'b1;
            durum_d = SONUC;
          end else begin
            ret_d    = 1'b0;
            yuk_d    = yeni[YUK_W-1:0];
            yolcu_d  = yolcu_q + YOLCU_W'(1);
            duz_d    = (yeni < (YUK_W + 1)'(ESIK));
            bolBasla = 1'b1;
            durum_d  = HESAP;
          end
        end
      end
      HESAP: begin
        if (kapat) kapat_d = 1'b1;
        if (bolBitti) durum_d = SONUC;
      end
      SONUC: begin
        if (kapat) kapat_d = 1'b1;
        bitti_d = 1'b1;
        red_d   = ret_q;
        if (ret_q) begin
          ucret_d = '0;
        end else if (duz_q) begin
          ucret_d = UCRET_W'(doyur(32'(SABIT_UCRET), UCRET_W));
        end else begin
          ucret_d = UCRET_W'(doyur(32'(bolum), UCRET_W));
        end
        durum_d = kapanis ? KAPALI : BOS;
      end
      KAPALI: begin
        durum_d = KAPALI;
      end
      default: begin
        durum_d = BOS;
      end
    endcase
  end

  // State and output registers; reset clears everything and returns to BOS.
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      durum_q <= BOS;
      yuk_q   <= '0;
      yolcu_q <= '0;
      ucret_q <= '0;
      red_q   <= 1'b0;
      bitti_q <= 1'b0;
      kapat_q <= 1'b0;
      duz_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      durum_q <= durum_d;
      yuk_q   <= yuk_d;
      yolcu_q <= yolcu_d;
      ucret_q <= ucret_d;
      red_q   <= red_d;
      bitti_q <= bitti_d;
      kapat_q <= kapat_d;
      duz_q   <= duz_d;
      ret_q   <= ret_d;
    end
  end

  assign hazir        = (durum_q == BOS);
  assign kapandi      = (durum_q == KAPALI);
  assign bitti        = bitti_q;
  assign red          = red_q;
  assign ucret        = ucret_q;
  assign toplam_yuk   = yuk_q;
  assign yolcu_sayisi = yolcu_q;

endmodule
